golomb_unpacker: RTL

GOLOMB_UNPACKER -- requirements
Module: golomb_unpacker

---
 rtl/jpegls_pkg.sv | 16 +
 rtl/golomb_unpacker_lzc32.sv | 12 +
 rtl/golomb_unpacker.sv | 112 +++++++++++
 3 files changed

// File: rtl/jpegls_pkg.sv
// Shared JPEG-LS constants: Golomb code limits, bit-buffer sizing and the
// unpacker state encoding (also used by the encoder side).
package jpegls_pkg;
  localparam int LIMIT  = 32;
  localparam int QBPP   = 8;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 7;
  localparam int MVAL_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;
endpackage

// File: rtl/golomb_unpacker_lzc32.sv
// Leading-zero count of a 32-bit word; all-zero input yields 32.
module lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  zcnt
);
  // Scanning upward leaves the highest set bit as the final winner.
  always_comb begin
    zcnt = 6'd32;
    for (int i = 0; i < 32; i++)
      if (din[i]) zcnt = 6'(31 - i);
  end
endmodule

// File: rtl/golomb_unpacker.sv
// Golomb/escape symbol decoder fed by 32-bit MSB-first words; one symbol per
// k request, decoded from a 64-bit MSB-aligned bit buffer.
module golomb_unpacker #(
  parameter int LIMIT = jpegls_pkg::LIMIT,
  parameter int QBPP  = jpegls_pkg::QBPP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [3:0]  k_in,
  input  logic        k_valid,
  output logic        k_ready,
  input  logic        flush,
  output logic [19:0] mval,
  output logic        mval_valid,
  output logic        mval_escape,
  output logic        err
);
  import jpegls_pkg::*;

  localparam int Q = LIMIT - QBPP - 1;
  localparam logic [CNT_W-1:0] Q_C     = CNT_W'(Q);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  state_t           state;
  logic [BUF_W-1:0] bbuf, shifted, appended, buf_nx;
  logic [CNT_W-1:0] cnt, lz_w, zmin, need_norm, consumed, remain, cnt_nx;
  logic [3:0]       k_q;
  logic [5:0]       lz, kbase;
  logic [15:0]      kwin, kbits;
  logic [QBPP-1:0]  esc_bits;
  logic [19:0]      mval_norm, mval_esc;
  logic             have_one, do_norm, do_esc, do_err, accept;

  lzc32 u_lzc (.din(bbuf[BUF_W-1 -: 32]), .zcnt(lz));

  assign word_ready = (cnt <= CNT_W'(32)) && !err;
  assign k_ready    = (state == ST_IDLE);
  assign accept     = word_valid && word_ready;

  always_comb begin
    lz_w      = CNT_W'(lz);
    // Bits below cnt are always zero, so a 1 at lz < cnt is a real terminator.
    have_one  = lz_w < cnt;
    zmin      = have_one ? lz_w : cnt;
    need_norm = lz_w + CNT_W'(k_q) + 7'd1;
    do_norm   = (state == ST_DECODE) && have_one && (lz_w < Q_C) && (cnt >= need_norm);
    do_esc    = (state == ST_DECODE) && have_one && (lz_w == Q_C) && (cnt >= LIMIT_C);
    do_err    = (state == ST_DECODE) && (zmin > Q_C);

    kbase     = 6'd62 - lz;
    kwin      = bbuf[kbase -: 16];
    kbits     = kwin >> (5'd16 - {1'b0, k_q});
    mval_norm = (20'(lz) << k_q) | 20'(kbits);
    esc_bits  = bbuf[BUF_W-2-Q -: QBPP];
    mval_esc  = 20'(esc_bits) + 20'd1;

    consumed  = do_norm ? need_norm : (do_esc ? LIMIT_C : '0);
    shifted   = bbuf << consumed;
    remain    = cnt - consumed;
    // New word lands directly below whatever survives this cycle's consume.
    appended  = accept ? ({word_in, 32'b0} >> remain) : '0;
    buf_nx    = shifted | appended;
    cnt_nx    = accept ? remain + 7'd32 : remain;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bbuf        <= '0;
      cnt         <= '0;
      k_q         <= '0;
      mval        <= '0;
      mval_valid  <= 1'b0;
      mval_escape <= 1'b0;
      err         <= 1'b0;
    end else begin
      mval_valid  <= 1'b0;
      mval_escape <= 1'b0;
      if (flush && state != ST_DECODE) begin
        state <= ST_IDLE;
        bbuf  <= '0;
        cnt   <= '0;
        err   <= 1'b0;
      end else begin
        bbuf <= buf_nx;
        cnt  <= cnt_nx;
        case (state)
          ST_IDLE: if (k_valid) begin
            k_q   <= k_in;
            state <= ST_DECODE;
          end
          ST_DECODE: begin
            if (do_norm || do_esc) begin
              mval        <= do_esc ? mval_esc : mval_norm;
              mval_valid  <= 1'b1;
              mval_escape <= do_esc;
              state       <= ST_IDLE;
            end else if (do_err) begin
              err   <= 1'b1;
              state <= ST_ERROR;
            end
          end
          ST_ERROR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
